// File: rtl/adc_spi_pkg.sv
// Shared types and frame-geometry helpers for the multi-channel LTC2315-class SPI reader.
package adc_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      QUIET
   } state_t;

   function automatic int unsigned frame_len(input int unsigned sck_div,
                                             input int unsigned frame_bits,
                                             input int unsigned t_quiet);
      return sck_div + 2 * sck_div * frame_bits + t_quiet;
   endfunction

   function automatic int unsigned sck_period(input int unsigned sck_div);
      return 2 * sck_div;
   endfunction

   function automatic int unsigned data_lsb(input int unsigned frame_bits,
                                            input int unsigned lead_bits,
                                            input int unsigned data_bits);
      return frame_bits - lead_bits - data_bits;
   endfunction

   function automatic bit layout_ok(input int unsigned frame_bits,
                                    input int unsigned lead_bits,
                                    input int unsigned data_bits);
      return (lead_bits + data_bits) <= frame_bits;
   endfunction

   localparam int unsigned DEFAULT_FRAME_LEN  = frame_len(2, 16, 4);
   localparam int unsigned DEFAULT_SCK_PERIOD = sck_period(2);
   localparam int unsigned DEFAULT_DATA_LSB   = data_lsb(16, 1, 12);

endpackage

// File: rtl/adc_spi_lane.sv
// One channel's deserialiser: MSB-first shift register, shifted on each SCK rising edge.
module adc_spi_lane #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned LEAD_BITS  = 1,
   parameter int unsigned DATA_BITS  = 12
) (
   input  logic                 clk_100,
   input  logic                 reset,
   input  logic                 shift_en,
   input  logic                 sdo,
   output logic [DATA_BITS-1:0] data
);

   // Leading bits fall off the top after FRAME_BITS shifts, so they need no storage.
   localparam int unsigned SREG_BITS = FRAME_BITS - LEAD_BITS;

   logic [SREG_BITS-1:0] sreg;

   // NOTE: shift registers are reset so an aborted frame never leaks into a later result.
   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) sreg <= '0;
      else if (shift_en) sreg <= {sreg[SREG_BITS-2:0], sdo};
   end

   assign data = sreg[SREG_BITS-1 -: DATA_BITS];

endmodule

// File: rtl/adc_spi_array.sv
// Sequencer for N_CH ADCs on a shared SCK/CS pair; all channels are deserialised in parallel.
module adc_spi_array
   import adc_spi_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned DATA_BITS  = 12,
   parameter int unsigned LEAD_BITS  = 1,
   parameter int unsigned SCK_DIV    = 2,
   parameter int unsigned T_QUIET    = 4
) (
   input  logic                      clk_100,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      cont,
   input  logic [N_CH-1:0]           sdo,
   output logic                      sck,
   output logic                      CS,
   output logic                      busy,
   output logic                      en,
   output logic [N_CH*DATA_BITS-1:0] adc_data,
   output logic                      overrun
);

   if (!layout_ok(FRAME_BITS, LEAD_BITS, DATA_BITS)) begin : g_layout_check
      $error("adc_spi_array: LEAD_BITS + DATA_BITS exceeds FRAME_BITS");
   end

   localparam int unsigned CNT_MAX = (SCK_DIV > T_QUIET) ? SCK_DIV : T_QUIET;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

   localparam logic [CNT_W-1:0] SCK_LAST   = CNT_W'(SCK_DIV - 1);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(T_QUIET - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

   state_t                          state;
   logic [CNT_W-1:0]                cnt;
   logic [BIT_W-1:0]                bit_cnt;
   logic                            shift_en;
   logic [N_CH-1:0][DATA_BITS-1:0]  lane_data;

   // NOTE: shift_en is decoded combinationally so lanes sample sdo on the very edge that raises sck.
   assign shift_en = (state == SHIFT) && !sck && (cnt == SCK_LAST);

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      adc_spi_lane #(
         .FRAME_BITS(FRAME_BITS),
         .LEAD_BITS (LEAD_BITS),
         .DATA_BITS (DATA_BITS)
      ) u_lane (
         .clk_100 (clk_100),
         .reset   (reset),
         .shift_en(shift_en),
         .sdo     (sdo[i]),
         .data    (lane_data[i])
      );
   end

   // NOTE: all state and outputs use non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         sck      <= 1'b0;
         CS       <= 1'b1;
         busy     <= 1'b0;
         en       <= 1'b0;
         overrun  <= 1'b0;
         adc_data <= '0;
      end else begin
         en <= 1'b0;
         if (state != IDLE && start && !cont) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (start || cont) begin
                  state <= SETUP;
                  CS    <= 1'b0;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  if (start) overrun <= 1'b0;
               end
            end
            SETUP: begin
               if (cnt == SCK_LAST) begin
                  state   <= SHIFT;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == SCK_LAST) begin
                  cnt <= '0;
                  sck <= ~sck;
                  // End of a high phase closes one bit; the last one also closes the frame.
                  if (sck) begin
                     if (bit_cnt == BIT_LAST) begin
                        state <= QUIET;
                        CS    <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            QUIET: begin
               if (cnt == QUIET_LAST) begin
                  en  <= 1'b1;
                  cnt <= '0;
                  for (int i = 0; i < int'(N_CH); i++)
                     adc_data[i*DATA_BITS +: DATA_BITS] <= lane_data[i];
                  if (cont) begin
                     state <= SETUP;
                     CS    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_array.sv
// Randomised scoreboard bench for adc_spi_array, plus a directed run of a fast 14-bit configuration.
module tb_adc_spi_array;

   localparam int N_CH = 4;
   localparam int FB   = 16;
   localparam int DB   = 12;
   localparam int LB   = 1;
   localparam int SD   = 2;
   localparam int TQ   = 4;
   localparam int L    = SD + 2 * SD * FB + TQ;   // 70
   localparam int RSH  = FB - LB - DB;            // result sits this far above bit 0

   logic                 clk_100 = 1'b0;
   logic                 reset, start, cont;
   logic [N_CH-1:0]      sdo;
   logic                 sck, CS, busy, en, overrun;
   logic [N_CH*DB-1:0]   adc_data;

   logic                 start2, cont2;
   logic [1:0]           sdo2;
   logic                 sck2, cs2, busy2, en2, overrun2;
   logic [23:0]          adc_data2;

   always #5 clk_100 = ~clk_100;

   adc_spi_array #(
      .N_CH(N_CH), .FRAME_BITS(FB), .DATA_BITS(DB),
      .LEAD_BITS(LB), .SCK_DIV(SD), .T_QUIET(TQ)
   ) dut (
      .clk_100(clk_100), .reset(reset), .start(start), .cont(cont), .sdo(sdo),
      .sck(sck), .CS(CS), .busy(busy), .en(en), .adc_data(adc_data), .overrun(overrun)
   );

   adc_spi_array #(
      .N_CH(2), .FRAME_BITS(14), .DATA_BITS(12),
      .LEAD_BITS(0), .SCK_DIV(1), .T_QUIET(4)
   ) dut2 (
      .clk_100(clk_100), .reset(reset), .start(start2), .cont(cont2), .sdo(sdo2),
      .sck(sck2), .CS(cs2), .busy(busy2), .en(en2), .adc_data(adc_data2), .overrun(overrun2)
   );

   typedef struct {
      logic [N_CH*DB-1:0] data;
      int                 due;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          use_fixed = 1'b0;
   logic [15:0] fixed [N_CH];
   logic [15:0] frm   [N_CH];
   int          idx = 0;
   logic        prev_cs = 1'b1;
   logic        prev_sck = 1'b0;
   logic [13:0] frm2 = 14'h3FFC;
   int          idx2 = 0;
   logic        prev_cs2 = 1'b1;
   logic        prev_sck2 = 1'b0;

   always @(posedge clk_100) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [DB-1:0] model_result(input logic [15:0] frame);
      return DB'((frame >> RSH) & ((1 << DB) - 1));
   endfunction

   // ADC model + scoreboard producer/consumer, all on the falling clk edge.
   initial for (int c = 0; c < N_CH; c++) begin
      frm[c]   = '0;
      fixed[c] = '0;
   end

   always @(negedge clk_100) begin
      exp_t e;
      if (prev_cs && !CS) begin
         e.data = '0;
         for (int c = 0; c < N_CH; c++) begin
            frm[c] = use_fixed ? fixed[c] : 16'($urandom);
            e.data[c*DB +: DB] = model_result(frm[c]);
         end
         e.due = cyc + L;
         exp_q.push_back(e);
         idx = FB - 1;
      end else if (prev_sck && !sck && !CS && idx > 0) begin
         idx--;
      end
      for (int c = 0; c < N_CH; c++) sdo[c] = frm[c][idx];
      prev_cs  = CS;
      prev_sck = sck;
      if (en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_en", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("adc_data", adc_data, e.data);
            check("en_cycle", cyc, e.due);
         end
      end
   end

   always @(negedge clk_100) begin
      if (prev_cs2 && !cs2) idx2 = 13;
      else if (prev_sck2 && !sck2 && !cs2 && idx2 > 0) idx2--;
      sdo2     = {1'b0, frm2[idx2]};
      prev_cs2  = cs2;
      prev_sck2 = sck2;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_100);
      #1;
   endtask

   task automatic pulse_start(output int k);
      start = 1'b1;
      tick(1);
      k = cyc;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      check("idle_within_budget", busy, 0);
   endtask

   initial begin
      int k, k2, bad_cs, bad_sck, bad_busy, rises, first_rise, en_at;
      logic [23:0] d2;
      logic ps;

      reset = 1'b1; start = 1'b0; cont = 1'b0; start2 = 1'b0; cont2 = 1'b0;
      tick(3);
      check("rst_cs", CS, 1);
      check("rst_sck", sck, 0);
      check("rst_busy", busy, 0);
      check("rst_en", en, 0);
      check("rst_overrun", overrun, 0);
      check("rst_data", adc_data, 0);
      reset = 1'b0;
      tick(2);

      // Single shot, channel 0 only.
      use_fixed = 1'b1;
      fixed = '{16'h55E0, 16'h0000, 16'h0000, 16'h0000};
      pulse_start(k);
      check("t1_cs_low", CS, 0);
      check("t1_busy", busy, 1);
      tick(3);
      check("t1_sck_before_rise", sck, 0);
      tick(1);
      check("t1_first_sck_rise", sck, 1);
      tick(L - 5);
      check("t1_busy_at_L-1", busy, 1);
      check("t1_en_early", en, 0);
      tick(1);
      check("t1_busy_falls_at_L", busy, 0);
      check("t1_en_at_L", en, 1);
      check("t1_ch0", adc_data[11:0], 12'hABC);
      check("t1_ch1to3", adc_data[47:12], 0);
      tick(3);

      // All four channels distinct.
      fixed = '{16'h7FF8, 16'h0008, 16'h4000, 16'h2AA8};
      pulse_start(k);
      wait_idle(L + 5);
      check("t2_all_channels", adc_data, 48'h555_800_001_FFF);
      tick(2);

      // Start during a frame sets overrun without disturbing the frame.
      use_fixed = 1'b0;
      pulse_start(k);
      tick(19);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("t3_overrun_set", overrun, 1);
      check("t3_still_busy", CS, 0);
      wait_idle(L + 5);
      check("t3_frame_len", cyc - k, L);
      check("t3_overrun_sticky", overrun, 1);
      tick(2);
      pulse_start(k2);
      check("t3_overrun_cleared", overrun, 0);
      wait_idle(L + 5);
      tick(2);

      // Continuous mode: three frames, start ignored, cont dropped during the third.
      cont = 1'b1;
      tick(1);
      k = cyc;
      bad_cs = 0; bad_sck = 0; bad_busy = 0;
      for (int m = 0; m <= 3 * L; m++) begin
         int p;
         logic cs_exp, sck_exp, busy_exp;
         p        = m % L;
         busy_exp = (m < 3 * L);
         cs_exp   = (m < 3 * L) ? (p >= L - TQ) : 1'b1;
         sck_exp  = (m < 3 * L) && (p >= SD) && (p < L - TQ) && (((p - SD) % (2 * SD)) >= SD);
         if (CS !== cs_exp) bad_cs++;
         if (sck !== sck_exp) bad_sck++;
         if (busy !== busy_exp) bad_busy++;
         if (m == 100) start = 1'b1;
         if (m == 101) start = 1'b0;
         if (m == 150) cont = 1'b0;
         if (m < 3 * L) tick(1);
      end
      check("t4_cs_pattern_errors", bad_cs, 0);
      check("t4_sck_pattern_errors", bad_sck, 0);
      check("t4_busy_pattern_errors", bad_busy, 0);
      check("t4_no_overrun_in_cont", overrun, 0);
      tick(L + 10);
      check("t4_back_to_idle", {busy, CS}, 2'b01);

      // Reset mid-SHIFT aborts the frame with no delivery.
      pulse_start(k);
      tick(29);
      reset = 1'b1;
      #1;
      exp_q.delete();
      check("t5_cs_on_reset", CS, 1);
      check("t5_sck_on_reset", sck, 0);
      check("t5_busy_on_reset", busy, 0);
      check("t5_data_on_reset", adc_data, 0);
      tick(1);
      reset = 1'b0;
      tick(L + 20);
      check("t5_data_after_abort", adc_data, 0);
      pulse_start(k);
      wait_idle(L + 5);
      tick(2);

      // Randomised single shots with random gaps.
      for (int it = 0; it < 8; it++) begin
         tick($urandom_range(1, 6));
         pulse_start(k);
         wait_idle(L + 5);
      end
      tick(3);
      check("scoreboard_drained", exp_q.size(), 0);

      // Fast configuration: SCK_DIV=1, 14-bit frame, no lead bits, L=33.
      start2 = 1'b1;
      tick(1);
      k = cyc;
      start2 = 1'b0;
      rises = 0; first_rise = -1; en_at = -1; d2 = '0;
      ps = sck2;
      for (int m = 1; m <= 40; m++) begin
         tick(1);
         if (!ps && sck2) begin
            rises++;
            if (first_rise < 0) first_rise = m;
         end
         ps = sck2;
         if (en2 && en_at < 0) begin
            en_at = m;
            d2    = adc_data2;
         end
      end
      check("cfg2_sck_rises", rises, 14);
      check("cfg2_first_rise", first_rise, 2);
      check("cfg2_en_offset", en_at, 33);
      check("cfg2_data", d2, 24'h000_FFF);
      check("cfg2_idle", busy2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
